// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// the watchdog width and default timeout, and the round-robin pick helper.
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no owner, slave cycle closed
    ST_BUS  = 2'd1,  // owner connected, waiting for an accepted strobe
    ST_PEND = 2'd2   // one strobe accepted, waiting for the slave ACK
  } arb_state_e;

  localparam int unsigned WDOG_WIDTH      = 32'd8;
  localparam int unsigned TIMEOUT_DEFAULT = 32'd255;

  // Returns the index of the master to grant. A lone requester always wins;
  // on a tie the master that did not own the bus last time wins.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last);
    logic win;
    if (req0 && req1) begin
      win = ~last;
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// One Wishbone B.4 pipelined link. The arbiter sees each master link through
// the slave modport and the shared slave link through the master modport.
//   cyc/stb/we/adr/dat_w : request side (master -> slave)
//   dat_r/ack/stall/err  : response side (slave -> master)
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32'd16,
  parameter int unsigned DATA_WIDTH = 32'd16
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] dat_w;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ack;
  logic                  stall;
  logic                  err;

  modport master (
    output cyc, stb, we, adr, dat_w,
    input  dat_r, ack, stall, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w,
    output dat_r, ack, stall, err
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arb_watchdog
// 8-bit clear/increment counter measuring how long the arbiter has waited for
// a slave ACK. expired is high during the LIMIT-th waiting cycle, so a
// transfer gets exactly LIMIT cycles for its ACK before it is abandoned.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : restart the count (transfer accepted)
//   inc        : count one waiting cycle (saturates at 8'hFF)
//   expired    : current waiting cycle is the last one allowed
// ---------------------------------------------------------------------------
module wb_arb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WDOG_WIDTH-1:0] LAST_COUNT = WDOG_WIDTH'(LIMIT - 32'd1);
  localparam logic [WDOG_WIDTH-1:0] MAX_COUNT  = {WDOG_WIDTH{1'b1}};

  logic [WDOG_WIDTH-1:0] count_r;

  // Wait-cycle counter: clear wins over increment, increment saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {WDOG_WIDTH{1'b0}};
    end else if (clr) begin
      count_r <= {WDOG_WIDTH{1'b0}};
    end else if (inc && (count_r != MAX_COUNT)) begin
      count_r <= count_r + {{(WDOG_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_COUNT);

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Round-robin arbiter connecting two pipelined Wishbone masters to a single
// slave with at most one outstanding transfer. The owner keeps the bus until
// it drops cyc; a transfer whose ACK does not arrive within TIMEOUT cycles
// is terminated with err to the owner.
//   clk_i   : clock, all state changes on the rising edge
//   reset_i : asynchronous active-low reset
//   m0, m1  : master links (request in, ack/stall/err/dat_r out)
//   s       : shared slave link (request out, ack/stall/dat_r in)
// Request and response paths are combinational pass-throughs of the owner.
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32'd16,
  parameter int unsigned DATA_WIDTH = 32'd16,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input logic         clk_i,
  input logic         reset_i,
  wb_arbiter_if.slave  m0,
  wb_arbiter_if.slave  m1,
  wb_arbiter_if.master s
);

  arb_state_e state_r, state_s;
  logic       owner_r, owner_s;
  logic       last_r, last_s;

  logic                  own_cyc_s, own_stb_s, own_we_s;
  logic [ADDR_WIDTH-1:0] own_adr_s;
  logic [DATA_WIDTH-1:0] own_dat_s;

  logic                  bus_cyc_s, bus_stb_s, bus_we_s;
  logic [ADDR_WIDTH-1:0] bus_adr_s;
  logic [DATA_WIDTH-1:0] bus_dat_s;
  logic                  own_stall_s, ack_s, err_s;
  logic                  wdog_clr_s, wdog_inc_s, wdog_expired_s;

  assign own_cyc_s = owner_r ? m1.cyc   : m0.cyc;
  assign own_stb_s = owner_r ? m1.stb   : m0.stb;
  assign own_we_s  = owner_r ? m1.we    : m0.we;
  assign own_adr_s = owner_r ? m1.adr   : m0.adr;
  assign own_dat_s = owner_r ? m1.dat_w : m0.dat_w;

  wb_arb_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk_i),
    .rst_n   (reset_i),
    .clr     (wdog_clr_s),
    .inc     (wdog_inc_s),
    .expired (wdog_expired_s)
  );

  // State, owner and round-robin history registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      last_r  <= last_s;
    end
  end

  // Next-state logic and the combinational bus/response outputs.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    last_s      = last_r;
    bus_cyc_s   = 1'b0;
    bus_stb_s   = 1'b0;
    bus_we_s    = 1'b0;
    bus_adr_s   = {ADDR_WIDTH{1'b0}};
    bus_dat_s   = {DATA_WIDTH{1'b0}};
    own_stall_s = 1'b1;
    ack_s       = 1'b0;
    err_s       = 1'b0;
    wdog_clr_s  = 1'b0;
    wdog_inc_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (m0.cyc || m1.cyc) begin
          owner_s = pick_winner(m0.cyc, m1.cyc, last_r);
          state_s = ST_BUS;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUS: begin
        // cyc follows the owner so a release closes the slave cycle at once.
        bus_cyc_s   = own_cyc_s;
        bus_stb_s   = own_cyc_s & own_stb_s;
        bus_we_s    = own_we_s;
        bus_adr_s   = own_adr_s;
        bus_dat_s   = own_dat_s;
        own_stall_s = s.stall;
        if (!own_cyc_s) begin
          last_s  = owner_r;
          state_s = ST_IDLE;
        end else if (own_stb_s && !s.stall) begin
          wdog_clr_s = 1'b1;
          state_s    = ST_PEND;
        end else begin
          state_s = ST_BUS;
        end
      end

      ST_PEND: begin
        bus_cyc_s  = own_cyc_s;
        bus_we_s   = own_we_s;
        bus_adr_s  = own_adr_s;
        bus_dat_s  = own_dat_s;
        wdog_inc_s = 1'b1;
        // ACK is checked first so it beats a same-cycle timeout.
        if (s.ack) begin
          ack_s = 1'b1;
          if (own_cyc_s) begin
            state_s = ST_BUS;
          end else begin
            last_s  = owner_r;
            state_s = ST_IDLE;
          end
        end else if (!own_cyc_s) begin
          last_s  = owner_r;
          state_s = ST_IDLE;
        end else if (wdog_expired_s) begin
          err_s     = 1'b1;
          bus_cyc_s = 1'b0;
          last_s    = owner_r;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_PEND;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign s.cyc   = bus_cyc_s;
  assign s.stb   = bus_stb_s;
  assign s.we    = bus_we_s;
  assign s.adr   = bus_adr_s;
  assign s.dat_w = bus_dat_s;

  // The non-owner always sees stall and never sees ack or err.
  assign m0.stall = owner_r ? 1'b1 : own_stall_s;
  assign m1.stall = owner_r ? own_stall_s : 1'b1;
  assign m0.ack   = ack_s & ~owner_r;
  assign m1.ack   = ack_s & owner_r;
  assign m0.err   = err_s & ~owner_r;
  assign m1.err   = err_s & owner_r;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Scenario bench for wb_arbiter (TIMEOUT=4). Inputs change 1 time unit after
// the rising edge, outputs are sampled on the falling edge. Expected values
// are queued when stimulus is driven and popped when the DUT responds.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

  logic clk_i = 1'b0;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];

  wb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m0_if ();
  wb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) m1_if ();
  wb_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) s_if ();

  wb_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .m0      (m0_if),
    .m1      (m1_if),
    .s       (s_if)
  );

  always #5 clk_i = ~clk_i;

  task automatic drive_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0; m0_if.adr = 16'h0; m0_if.dat_w = 16'h0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0; m1_if.adr = 16'h0; m1_if.dat_w = 16'h0;
    s_if.ack = 1'b0; s_if.stall = 1'b0; s_if.err = 1'b0; s_if.dat_r = 16'h0;
    @(negedge clk_i);
    checks++;
    if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b000) begin
      errors++; $display("FAIL reset_bus got %b want 000", {s_if.cyc, s_if.stb, s_if.we});
    end
    checks++;
    if ({s_if.adr, s_if.dat_w} !== 32'h0) begin
      errors++; $display("FAIL reset_adr_dat got %h want 0", {s_if.adr, s_if.dat_w});
    end
    checks++;
    if ({m0_if.stall, m1_if.stall} !== 2'b11) begin
      errors++; $display("FAIL reset_stall got %b want 11", {m0_if.stall, m1_if.stall});
    end
    checks++;
    if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ack_err got %b want 0000", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err});
    end
    drive_step();
    reset_i = 1'b1;
    drive_step();
  endtask

  // Three rounds: tie (m0 then m1), m0 alone, tie again (m1 then m0).
  task automatic test_round_robin();
    logic [31:0] e;
    logic        live0, live1, acc, who, ack_who;
    for (int p = 0; p < 3; p++) begin
      if (p == 0) begin
        exp_q.push_back({16'h1000, 16'hD000}); exp_q.push_back({16'h2000, 16'hE000});
      end else if (p == 1) begin
        exp_q.push_back({16'h1001, 16'hD001});
      end else begin
        exp_q.push_back({16'h2002, 16'hE002}); exp_q.push_back({16'h1002, 16'hD002});
      end
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b1;
      m0_if.adr = 16'h1000 + 16'(p); m0_if.dat_w = 16'hD000 + 16'(p);
      live0 = 1'b1;
      live1 = (p != 1);
      m1_if.cyc = live1; m1_if.stb = live1; m1_if.we = 1'b1;
      m1_if.adr = 16'h2000 + 16'(p); m1_if.dat_w = 16'hE000 + 16'(p);
      ack_who = 1'b0;
      for (int c = 0; c < 40 && (live0 || live1); c++) begin
        @(negedge clk_i);
        acc = s_if.cyc && s_if.stb && !s_if.stall;
        who = (m0_if.stall === 1'b0) ? 1'b0 : 1'b1;
        if (acc) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
          checks++;
          if ({s_if.adr, s_if.dat_w} !== e) begin
            errors++; $display("FAIL rr_order round %0d got %h want %h", p, {s_if.adr, s_if.dat_w}, e);
          end
        end
        if (s_if.ack) begin
          checks++;
          if ({m0_if.ack, m1_if.ack} !== (ack_who ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL rr_ack round %0d got %b want %b", p, {m0_if.ack, m1_if.ack}, (ack_who ? 2'b01 : 2'b10));
          end
        end
        drive_step();
        if (s_if.ack) begin
          s_if.ack = 1'b0;
          if (ack_who) begin m1_if.cyc = 1'b0; live1 = 1'b0; end
          else begin m0_if.cyc = 1'b0; live0 = 1'b0; end
        end
        if (acc) begin
          if (who) m1_if.stb = 1'b0; else m0_if.stb = 1'b0;
          s_if.ack = 1'b1;
          ack_who = who;
        end
      end
      checks++;
      if ({live0, live1} !== 2'b00 || exp_q.size() != 0) begin
        errors++; $display("FAIL rr_done round %0d got live %b left %0d want live 00 left 0", p, {live0, live1}, exp_q.size());
        exp_q.delete();
      end
      drive_step();
    end
  endtask

  task automatic test_single();
    logic [31:0] e;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 16'h1234;
    exp_q.push_back({16'h0, 16'h1234});
    @(negedge clk_i);
    checks++;
    if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL single_idle_cyc got %b want 0", s_if.cyc); end
    drive_step();
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({s_if.cyc, s_if.stb, s_if.we, m0_if.stall, s_if.adr} !== {4'b1100, e[15:0]}) begin
      errors++; $display("FAIL single_grant got %b_%h want 1100_%h", {s_if.cyc, s_if.stb, s_if.we, m0_if.stall}, s_if.adr, e[15:0]);
    end
    drive_step();
    m0_if.stb = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_if.cyc, s_if.stb, m0_if.stall, m0_if.ack} !== 4'b1010) begin
      errors++; $display("FAIL single_pend got %b want 1010", {s_if.cyc, s_if.stb, m0_if.stall, m0_if.ack});
    end
    drive_step();
    s_if.ack = 1'b1; s_if.dat_r = 16'hBEEF;
    exp_q.push_back({16'h0, 16'hBEEF});
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({m0_if.ack, m1_if.ack, m0_if.dat_r} !== {2'b10, e[15:0]}) begin
      errors++; $display("FAIL single_ack got %b_%h want 10_%h", {m0_if.ack, m1_if.ack}, m0_if.dat_r, e[15:0]);
    end
    drive_step();
    s_if.ack = 1'b0; m0_if.cyc = 1'b0;
    @(negedge clk_i);
    checks++;
    if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL single_release got %b want 0", s_if.cyc); end
    drive_step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int          accepted;
    accepted = 0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 16'h3000;
    s_if.ack = 1'b1; s_if.stall = 1'b0;
    exp_q.push_back(32'b010);
    for (int k = 0; k < 10; k++) exp_q.push_back((k % 2 == 0) ? 32'b100 : 32'b011);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      if (s_if.stb && !s_if.stall) accepted++;
      checks++;
      if ({s_if.stb, m0_if.stall, m0_if.ack} !== e[2:0]) begin
        errors++; $display("FAIL b2b_cycle %0d got %b want %b", k, {s_if.stb, m0_if.stall, m0_if.ack}, e[2:0]);
      end
      drive_step();
    end
    checks++;
    if (accepted != 5) begin errors++; $display("FAIL b2b_rate got %0d want 5", accepted); end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; s_if.ack = 1'b0;
    @(negedge clk_i);
    checks++;
    if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", s_if.cyc); end
    drive_step();
  endtask

  task automatic test_timeout();
    logic [31:0] e;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 16'h7000;
    drive_step();
    @(negedge clk_i);
    checks++;
    if (s_if.stb !== 1'b1) begin errors++; $display("FAIL to_accept got %b want 1", s_if.stb); end
    drive_step();
    m0_if.stb = 1'b0;
    // {ack, err, s_cyc} for the four PEND cycles, then the IDLE cycle.
    exp_q.push_back(32'b001); exp_q.push_back(32'b001); exp_q.push_back(32'b001);
    exp_q.push_back(32'b010); exp_q.push_back(32'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if ({m0_if.ack, m0_if.err, s_if.cyc} !== e[2:0]) begin
        errors++; $display("FAIL to_cycle %0d got %b want %b", i + 1, {m0_if.ack, m0_if.err, s_if.cyc}, e[2:0]);
      end
      drive_step();
      if (i == 3) m0_if.cyc = 1'b0;
    end
  endtask

  task automatic test_abort();
    logic [31:0] e;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0; m0_if.adr = 16'h4000;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1; m1_if.adr = 16'h5000; m1_if.dat_w = 16'h5555;
    exp_q.push_back({16'h0, 16'h5000});
    drive_step();
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({m0_if.stall, m1_if.stall, s_if.adr} !== {2'b10, e[15:0]}) begin
      errors++; $display("FAIL abort_grant_m1 got %b_%h want 10_%h", {m0_if.stall, m1_if.stall}, s_if.adr, e[15:0]);
    end
    drive_step();
    m1_if.stb = 1'b0;
    drive_step();
    m1_if.cyc = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_if.cyc, m1_if.ack} !== 2'b00) begin
      errors++; $display("FAIL abort_cyc got %b want 00", {s_if.cyc, m1_if.ack});
    end
    drive_step();
    s_if.ack = 1'b1; s_if.dat_r = 16'h0BAD;
    @(negedge clk_i);
    checks++;
    if ({m0_if.ack, m1_if.ack, m1_if.err} !== 3'b000) begin
      errors++; $display("FAIL abort_late_ack got %b want 000", {m0_if.ack, m1_if.ack, m1_if.err});
    end
    drive_step();
    s_if.ack = 1'b0;
    exp_q.push_back({16'h0, 16'h4000});
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({m0_if.stall, m1_if.stall, s_if.adr} !== {2'b01, e[15:0]}) begin
      errors++; $display("FAIL abort_grant_m0 got %b_%h want 01_%h", {m0_if.stall, m1_if.stall}, s_if.adr, e[15:0]);
    end
  endtask

  // Entered with m0 owning the bus and its strobe about to be accepted.
  task automatic test_reset_pend();
    logic [31:0] e;
    drive_step();
    m0_if.stb = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({s_if.cyc, s_if.stb} !== 2'b10) begin
      errors++; $display("FAIL rst_pend_state got %b want 10", {s_if.cyc, s_if.stb});
    end
    #1;
    reset_i = 1'b0;
    s_if.ack = 1'b1;
    #1;
    checks++;
    if ({s_if.cyc, m0_if.stall, m1_if.stall, m0_if.ack, m0_if.err} !== 5'b01100) begin
      errors++; $display("FAIL rst_pend_async got %b want 01100", {s_if.cyc, m0_if.stall, m1_if.stall, m0_if.ack, m0_if.err});
    end
    drive_step();
    reset_i = 1'b1; s_if.ack = 1'b0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 16'h4100;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 16'h6000;
    exp_q.push_back({16'h0, 16'h4100});
    @(negedge clk_i);
    checks++;
    if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL rst_idle_cyc got %b want 0", s_if.cyc); end
    drive_step();
    @(negedge clk_i);
    e = exp_q.pop_front();
    checks++;
    if ({m0_if.stall, m1_if.stall, s_if.adr} !== {2'b01, e[15:0]}) begin
      errors++; $display("FAIL rst_tie_m0 got %b_%h want 01_%h", {m0_if.stall, m1_if.stall}, s_if.adr, e[15:0]);
    end
    drive_step();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    drive_step();
    drive_step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_reset_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout got running want finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
